// File: rtl/resp_park_pkg.sv
// Shared types and default sizing for the multi-beat response parking lot.
package resp_park_pkg;

    localparam int DEF_NUM_ROWS   = 4;
    localparam int DEF_NUM_COLS   = 4;
    localparam int DEF_BEATS      = 4;
    localparam int DEF_HEADROOM   = 1;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_RESP_WIDTH = 2;
    localparam int DEF_ID_WIDTH   = 4;
    localparam int DEF_TAG_WIDTH  = 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        COMPLETE,
        DRAINING
    } slot_state_e;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_RESP_WIDTH-1:0] resp;
    } beat_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]  orig_id;
        logic [DEF_TAG_WIDTH-1:0] tagid;
    } hdr_t;

endpackage

// File: rtl/resp_slot_buf.sv
// One UID's parking slot: beat array, write count, read pointer and slot state.
module resp_slot_buf
    import resp_park_pkg::*;
#(
    parameter int  BEATS = DEF_BEATS,
    localparam int CNT_W = $clog2(BEATS + 1),
    localparam int PTR_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_last,
    input  beat_t            wr_beat,
    input  hdr_t             wr_hdr,
    input  logic             grant,
    input  logic             rd_adv,
    input  logic             flush,
    output slot_state_e      state,
    output logic [CNT_W-1:0] wr_cnt,
    output beat_t            rd_beat,
    output hdr_t             hdr,
    output logic             rd_last
);

    beat_t            beats_q [BEATS];
    hdr_t             hdr_q;
    slot_state_e      state_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             flush_hit;

    assign flush_hit = flush && (state_q == FILLING || state_q == COMPLETE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_hit) begin
            state_q  <= EMPTY;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                state_q  <= wr_last ? COMPLETE : FILLING;
            end
            if (grant) begin
                state_q  <= DRAINING;
                rd_ptr_q <= '0;
            end
            if (rd_adv) begin
                if (rd_last) begin
                    state_q  <= EMPTY;
                    wr_cnt_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by state and counters.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            beats_q[wr_cnt_q[PTR_W-1:0]] <= wr_beat;
            if (state_q == EMPTY) begin
                hdr_q <= wr_hdr;
            end
        end
    end

    assign state   = state_q;
    assign wr_cnt  = wr_cnt_q;
    assign rd_beat = beats_q[rd_ptr_q];
    assign hdr     = hdr_q;
    assign rd_last = ({1'b0, rd_ptr_q} == (wr_cnt_q - CNT_W'(1)));

endmodule

// File: rtl/response_park_burst.sv
// Multi-beat response parking lot: per-UID slots filled beat-wise, drained on allocate.
// Optional RESP_PARK_FLUSH_EN adds flush_req/flush_uid/flush_ack to discard parked slots.
module response_park_burst
    import resp_park_pkg::*;
#(
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int NUM_COLS   = DEF_NUM_COLS,
    parameter int MAX_REQ    = NUM_ROWS * NUM_COLS,
    parameter int UID_W      = $clog2(NUM_ROWS) + $clog2(NUM_COLS),
    parameter int BEATS      = DEF_BEATS,
    parameter int HEADROOM   = DEF_HEADROOM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RESP_WIDTH = DEF_RESP_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [UID_W-1:0]               in_uid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [RESP_WIDTH-1:0]          in_resp,
    input  logic [ID_WIDTH-1:0]            in_orig_id,
    input  logic [TAG_WIDTH-1:0]           in_tagid,
    input  logic                           in_last,
    input  logic                           alloc_req,
    input  logic [UID_W-1:0]               alloc_uid,
    output logic                           alloc_gnt,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [UID_W-1:0]               out_uid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [RESP_WIDTH-1:0]          out_resp,
    output logic [ID_WIDTH-1:0]            out_orig_id,
    output logic [TAG_WIDTH-1:0]           out_tagid,
    output logic                           out_last,
`ifdef RESP_PARK_FLUSH_EN
    input  logic                           flush_req,
    input  logic [UID_W-1:0]               flush_uid,
    output logic                           flush_ack,
`endif
    output logic [$clog2(MAX_REQ+1)-1:0]   used_cnt,
    output logic                           err_overlen
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int UCW   = $clog2(MAX_REQ + 1);
    localparam int UW1   = UCW + 1;
    localparam int CAP   = MAX_REQ - HEADROOM;

    slot_state_e      slot_state  [MAX_REQ];
    logic [CNT_W-1:0] slot_wr_cnt [MAX_REQ];
    beat_t            slot_beat   [MAX_REQ];
    hdr_t             slot_hdr    [MAX_REQ];
    logic             slot_last   [MAX_REQ];

    drain_state_e     drain_q;
    logic [UID_W-1:0] cur_uid_q;
    logic             out_valid_q;
    logic [UCW-1:0]   used_cnt_q;

    slot_state_e      in_state;
    beat_t            in_beat;
    hdr_t             in_hdr;
    beat_t            cur_beat;
    hdr_t             cur_hdr;
    logic             in_fire;
    logic             in_first;
    logic             overlen;
    logic             hs;
    logic             last_hs;
    logic             flush_hit;
    logic             flush_blocks_in;
    logic [UID_W-1:0] flush_sel;
    logic [UCW:0]     used_sum;
    logic [UCW:0]     used_dec;

`ifdef RESP_PARK_FLUSH_EN
    assign flush_hit = !rst && flush_req &&
                       (slot_state[flush_uid] == FILLING || slot_state[flush_uid] == COMPLETE);
    assign flush_sel       = flush_uid;
    assign flush_blocks_in = flush_hit && (flush_uid == in_uid);
    assign flush_ack       = flush_hit;
`else
    assign flush_hit       = 1'b0;
    assign flush_sel       = '0;
    assign flush_blocks_in = 1'b0;
`endif

    assign in_state     = slot_state[in_uid];
    assign in_beat.data = in_data;
    assign in_beat.resp = in_resp;
    assign in_hdr.orig_id = in_orig_id;
    assign in_hdr.tagid   = in_tagid;

    // New UIDs are admitted only while system-wide headroom remains.
    always_comb begin
        in_ready = 1'b0;
        if (in_state == FILLING) begin
            in_ready = slot_wr_cnt[in_uid] < CNT_W'(BEATS);
        end else if (in_state == EMPTY) begin
            in_ready = used_cnt_q < UCW'(CAP);
        end
        if (flush_blocks_in) begin
            in_ready = 1'b0;
        end
    end

    assign in_fire     = !rst && in_valid && in_ready;
    assign in_first    = in_fire && (in_state == EMPTY);
    assign overlen     = in_fire && !in_last && (slot_wr_cnt[in_uid] == CNT_W'(BEATS - 1));
    assign err_overlen = overlen;

    assign alloc_gnt = !rst && (drain_q == IDLE) && alloc_req &&
                       (slot_state[alloc_uid] == COMPLETE);
    assign hs        = out_valid_q && out_ready;
    assign last_hs   = hs && slot_last[cur_uid_q];

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_slot
        resp_slot_buf #(.BEATS(BEATS)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (in_fire && (in_uid == UID_W'(i))),
            .wr_last (in_last || overlen),
            .wr_beat (in_beat),
            .wr_hdr  (in_hdr),
            .grant   (alloc_gnt && (alloc_uid == UID_W'(i))),
            .rd_adv  (hs && (cur_uid_q == UID_W'(i))),
            .flush   (flush_hit && (flush_sel == UID_W'(i))),
            .state   (slot_state[i]),
            .wr_cnt  (slot_wr_cnt[i]),
            .rd_beat (slot_beat[i]),
            .hdr     (slot_hdr[i]),
            .rd_last (slot_last[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q     <= IDLE;
            cur_uid_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (drain_q)
                IDLE: begin
                    if (alloc_gnt) begin
                        drain_q     <= DRAIN;
                        cur_uid_q   <= alloc_uid;
                        out_valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        drain_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: drain_q <= IDLE;
            endcase
        end
    end

    // Arrival, release and flush may coincide; the floor at zero guards against underflow.
    always_comb begin
        used_sum = {1'b0, used_cnt_q} + UW1'(in_first);
        used_dec = UW1'(last_hs) + UW1'(flush_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_cnt_q <= '0;
        end else if (used_sum >= used_dec) begin
            used_cnt_q <= UCW'(used_sum - used_dec);
        end else begin
            used_cnt_q <= '0;
        end
    end

    assign used_cnt = used_cnt_q;

    assign cur_beat    = slot_beat[cur_uid_q];
    assign cur_hdr     = slot_hdr[cur_uid_q];
    assign out_valid   = out_valid_q;
    assign out_uid     = out_valid_q ? cur_uid_q : '0;
    assign out_data    = out_valid_q ? cur_beat.data : '0;
    assign out_resp    = out_valid_q ? cur_beat.resp : '0;
    assign out_orig_id = out_valid_q ? cur_hdr.orig_id : '0;
    assign out_tagid   = out_valid_q ? cur_hdr.tagid : '0;
    assign out_last    = out_valid_q && slot_last[cur_uid_q];

endmodule

// File: doc/response_park_burst.md
Name: response_park_burst

Overview:
Multi-beat successor of the single-slot response parking lot. It holds up to BEATS beats per UID. A slot is eligible only once its last beat is received. On an explicit allocate request for a UID, the slot is drained beat-by-beat through a valid/ready output channel. The slot self-releases on the last-beat handshake, so no separate FREE is needed. It sits between the response collector and the reorder arbiter.

Parameters:
NUM_ROWS, 4, mesh rows
NUM_COLS, 4, mesh columns
MAX_REQ, NUM_ROWS*NUM_COLS, number of UIDs / slots
UID_W, $clog2(NUM_ROWS)+$clog2(NUM_COLS), UID width
BEATS, 4, max beats per UID (power of 2, >=2)
HEADROOM, 1, slots kept free system-wide; capacity = MAX_REQ-HEADROOM
DATA_WIDTH, 256, beat payload width
RESP_WIDTH, 2, per-beat response code
ID_WIDTH, 4, original transaction ID
TAG_WIDTH, 4, tag ID

Ports:
clk  in  1  clock, single clock domain
rst  in  1  synchronous active-high reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&in_ready
in_uid  in  UID_W  target slot
in_data  in  DATA_WIDTH  beat data
in_resp  in  RESP_WIDTH  beat response
in_orig_id  in  ID_WIDTH  original ID (latched from first beat)
in_tagid  in  TAG_WIDTH  tag (latched from first beat)
in_last  in  1  final beat of this UID
alloc_req  in  1  request to drain alloc_uid
alloc_uid  in  UID_W  requested slot
alloc_gnt  out  1  one-cycle grant pulse
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_uid  out  UID_W  UID being drained
out_data / out_resp / out_orig_id / out_tagid  out  per params  beat payload
out_last  out  1  final beat of drained UID
used_cnt  out  $clog2(MAX_REQ+1)  occupied slots (any state other than EMPTY)
err_overlen  out  1  pulse: BEATS-th beat arrived without in_last

Behaviour:
- Per-slot state:
  - EMPTY→FILLING on the first accepted beat.
  - FILLING→COMPLETE on an accepted beat with in_last.
  - COMPLETE→DRAINING on grant.
  - DRAINING→EMPTY on the out_last handshake.
  - A beat with in_last accepted on EMPTY goes directly to COMPLETE.
- Per slot: write count 0..BEATS, read pointer 0..BEATS-1.
- in_ready (combinational) is high only when:
  - slot is FILLING and wr_cnt<BEATS, or
  - slot is EMPTY and used_cnt_q < MAX_REQ-HEADROOM.
  - It is low for COMPLETE or DRAINING.
- Accepting the BEATS-th beat without in_last:
  - It is stored and forced to last, so the slot goes COMPLETE.
  - err_overlen pulses for that cycle.
- Drain FSM with states IDLE and DRAIN.
  - alloc_gnt=1 iff FSM is IDLE, alloc_req=1, and slot[alloc_uid] is COMPLETE. Otherwise the request is ignored; the requester retries.
  - Grant at cycle T → FSM in DRAIN, out_valid=1 from T+1, presenting beat 0 of that UID.
- Output beats:
  - Beat k is presented until out_valid&out_ready, then beat k+1 is presented the next cycle.
  - out_last=1 on beat wr_cnt-1.
  - out_* are zero whenever out_valid=0.
  - out_orig_id and out_tagid are constant over the burst.
- Last-beat handshake:
  - Slot goes EMPTY and used_cnt decrements.
  - FSM returns to IDLE; the earliest next grant is the following cycle.
- used_cnt accounting:
  - +1 on a first-beat accept, −1 on last-beat release.
  - If both happen in the same cycle, the net change is 0.
  - Saturates at 0 and never underflows.
- Same cycle, different UIDs: enqueue, grant and drain are independent. An enqueue to the draining UID is impossible because in_ready is low.
- Reset:
  - All slots EMPTY, FSM IDLE, used_cnt=0, pointers 0.
  - alloc_gnt=0, out_valid=0, out_*=0, err_overlen=0.
  - in_ready=1 (requires MAX_REQ>HEADROOM).
  - Reset mid-burst drops all data; out_valid is low the cycle after rst.

Optional Feature:
RESP_PARK_FLUSH_EN
- With it: adds ports flush_req (in, 1), flush_uid (in, UID_W) and flush_ack (out, 1 pulse).
  - A flush on a FILLING or COMPLETE slot returns it to EMPTY, decrements used_cnt and pulses flush_ack the same cycle.
  - A flush on a DRAINING or EMPTY slot is ignored (flush_ack=0).
  - Flush wins over enqueue to the same UID in the same cycle; that enqueue is not accepted, so in_ready is low.
- Without it: no flush ports; slots leave only via drain.

Decomposition:
- Package resp_park_pkg holds:
  - slot_state_e enum (EMPTY, FILLING, COMPLETE, DRAINING)
  - drain_state_e enum (IDLE, DRAIN)
  - beat_t struct {data, resp}
  - hdr_t struct {orig_id, tagid}
- Sub-module resp_slot_buf: one UID's BEATS-deep beat array, wr_cnt, rd_ptr and state. Instantiated MAX_REQ times via generate.

Test Plan:
- Reset, then 3 beats to UID 5 (last on beat 3), alloc 5 → alloc_gnt at T, beats 0..2 on T+1..T+3 with out_ready=1, out_last on beat 2, used_cnt 1→0.
- Fill 15 UIDs with 1-beat responses (MAX_REQ=16, HEADROOM=1) → in_ready=0 for a 16th new UID, still 1 for a FILLING UID.
- out_ready toggled 1/0 during a 4-beat drain → each beat held stable while stalled, no beat lost or duplicated.
- alloc to a FILLING UID, then to a COMPLETE UID while DRAIN is active → both alloc_gnt=0; granted after the drain ends plus 1 cycle.
- 4 beats to UID 2 with in_last=0 → err_overlen pulse on beat 4, slot COMPLETE, drains 4 beats with out_last on beat 3.
- First beat to UID 1 in the same cycle as the last-beat handshake of UID 0 → used_cnt unchanged; rst asserted mid-drain → out_valid=0 and used_cnt=0 next cycle.
